cond_unit: RTL and testbench

COND_UNIT -- requirements
Module: cond_unit

---
 rtl/cond_unit.sv | 180 ++++++++++++++++++
 tb/tb_cond_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - condition-code evaluation and flag register for instruction gating
//
// Purpose:
//   Resolves the condition code of each accepted instruction against the
//   flag register {N,Z,C,V}. It gates the instruction's register write,
//   memory write and branch requests with the result, and it updates the
//   flag register only when the instruction passes. Results appear one
//   cycle after accept.
//
// Optional feature:
//   COND_UNIT_SQUASH_CNT_EN - adds squash_cnt_o, a saturating 16-bit count
//   of accepted instructions that failed their condition.
//
// Ports:
//   clk          in   clock, all state updates on its rising edge
//   rst_n        in   synchronous reset, active-low
//   valid_i      in   an instruction is presented this cycle
//   cond_i[3:0]  in   condition code of the presented instruction
//   flags_i[3:0] in   ALU flags {N,Z,C,V} produced by the instruction
//   flag_we_i    in   [1] update N,Z   [0] update C,V
//   reg_we_i     in   unconditioned register write request
//   mem_we_i     in   unconditioned memory write request
//   pc_src_i     in   unconditioned branch request
//   stall_i      in   hold all state
//   flush_i      in   discard the presented instruction (overrides stall)
//   valid_o      out  registered outputs hold a resolved instruction
//   reg_we_o     out  condition-gated register write
//   mem_we_o     out  condition-gated memory write
//   pc_src_o     out  condition-gated branch
//   cond_ex_o    out  resolved instruction passed its condition
//   flags_o[3:0] out  current flag register {N,Z,C,V}
//   squash_cnt_o out  (COND_UNIT_SQUASH_CNT_EN only) failed-condition count

module cond_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [3:0]  cond_i,
    input  logic [3:0]  flags_i,
    input  logic [1:0]  flag_we_i,
    input  logic        reg_we_i,
    input  logic        mem_we_i,
    input  logic        pc_src_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        valid_o,
    output logic        reg_we_o,
    output logic        mem_we_o,
    output logic        pc_src_o,
    output logic        cond_ex_o,
    output logic [3:0]  flags_o
`ifdef COND_UNIT_SQUASH_CNT_EN
    ,
    output logic [15:0] squash_cnt_o
`endif
);

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;

    logic [3:0] flag_q;
    logic [3:0] flag_d;
    logic       f_n, f_z, f_c, f_v;
    logic       cex;
    logic       accept;

    logic       valid_q;
    logic       cex_q;
    logic       reg_we_q;
    logic       mem_we_q;
    logic       pc_src_q;

    assign f_n = flag_q[3];
    assign f_z = flag_q[2];
    assign f_c = flag_q[1];
    assign f_v = flag_q[0];

    // Reset is handled in the sequential block, so accept only needs the
    // pipeline controls here.
    assign accept = valid_i & ~stall_i & ~flush_i;

    // Condition is judged against the flags before this edge; the flags an
    // instruction writes only affect its successors.
    always_comb begin
        cex = 1'b0;
        case (cond_i)
            CC_EQ:   cex = f_z;
            CC_NE:   cex = ~f_z;
            CC_CS:   cex = f_c;
            CC_CC:   cex = ~f_c;
            CC_MI:   cex = f_n;
            CC_PL:   cex = ~f_n;
            CC_VS:   cex = f_v;
            CC_VC:   cex = ~f_v;
            CC_HI:   cex = f_c & ~f_z;
            CC_LS:   cex = ~f_c | f_z;
            CC_GE:   cex = (f_n == f_v);
            CC_LT:   cex = (f_n != f_v);
            CC_GT:   cex = ~f_z & (f_n == f_v);
            CC_LE:   cex = f_z | (f_n != f_v);
            default: cex = 1'b1;    // AL and the unassigned 1111 both execute
        endcase
    end

    // N,Z and C,V are written as independent pairs so that instructions that
    // only produce logical results leave carry/overflow untouched.
    always_comb begin
        flag_d = flag_q;
        if (accept && cex) begin
            if (flag_we_i[1]) begin
                flag_d[3:2] = flags_i[3:2];
            end
            if (flag_we_i[0]) begin
                flag_d[1:0] = flags_i[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            cex_q    <= 1'b0;
            reg_we_q <= 1'b0;
            mem_we_q <= 1'b0;
            pc_src_q <= 1'b0;
            flag_q   <= RESET_FLAGS;
        end else if (flush_i) begin
            valid_q  <= 1'b0;
            cex_q    <= 1'b0;
            reg_we_q <= 1'b0;
            mem_we_q <= 1'b0;
            pc_src_q <= 1'b0;
        end else if (!stall_i) begin
            // With valid_i low every gated output collapses to 0, which is
            // the bubble behaviour; flag_d already holds in that case.
            valid_q  <= valid_i;
            cex_q    <= valid_i & cex;
            reg_we_q <= valid_i & reg_we_i & cex;
            mem_we_q <= valid_i & mem_we_i & cex;
            pc_src_q <= valid_i & pc_src_i & cex;
            flag_q   <= flag_d;
        end
    end

    assign valid_o   = valid_q;
    assign cond_ex_o = cex_q;
    assign reg_we_o  = reg_we_q;
    assign mem_we_o  = mem_we_q;
    assign pc_src_o  = pc_src_q;
    assign flags_o   = flag_q;

`ifdef COND_UNIT_SQUASH_CNT_EN
    logic [15:0] squash_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            squash_cnt_q <= 16'h0000;
        end else if (accept && !cex && (squash_cnt_q != 16'hFFFF)) begin
            squash_cnt_q <= squash_cnt_q + 16'h0001;
        end
    end

    assign squash_cnt_o = squash_cnt_q;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - self-checking bench for cond_unit

module tb_cond_unit;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [3:0]  cond_i;
    logic [3:0]  flags_i;
    logic [1:0]  flag_we_i;
    logic        reg_we_i;
    logic        mem_we_i;
    logic        pc_src_i;
    logic        stall_i;
    logic        flush_i;
    logic        valid_o;
    logic        reg_we_o;
    logic        mem_we_o;
    logic        pc_src_o;
    logic        cond_ex_o;
    logic [3:0]  flags_o;
`ifdef COND_UNIT_SQUASH_CNT_EN
    logic [15:0] squash_cnt_o;
`endif

    cond_unit #(.RESET_FLAGS(4'b0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (valid_i),
        .cond_i    (cond_i),
        .flags_i   (flags_i),
        .flag_we_i (flag_we_i),
        .reg_we_i  (reg_we_i),
        .mem_we_i  (mem_we_i),
        .pc_src_i  (pc_src_i),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .valid_o   (valid_o),
        .reg_we_o  (reg_we_o),
        .mem_we_o  (mem_we_o),
        .pc_src_o  (pc_src_o),
        .cond_ex_o (cond_ex_o),
        .flags_o   (flags_o)
`ifdef COND_UNIT_SQUASH_CNT_EN
        ,
        .squash_cnt_o (squash_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  cond;
        logic [3:0]  fl;
        logic [1:0]  fwe;
        logic        rw, mw, pc, st, fu, rn;
        logic        evo, ecx, ero, emo, epo;
        logic [3:0]  efl;
        logic [15:0] esq;
    } vec_t;

    vec_t tbl [22];
    vec_t exp_q [$];
    int   tests = 0;
    int   fails = 0;
    int   sq_model;

    function automatic vec_t mk(logic v, logic [3:0] cond, logic [3:0] fl, logic [1:0] fwe,
                                logic rw, logic mw, logic pc, logic st, logic fu, logic rn,
                                logic evo, logic ecx, logic ero, logic emo, logic epo,
                                logic [3:0] efl, logic [15:0] esq);
        vec_t r;
        r.v = v; r.cond = cond; r.fl = fl; r.fwe = fwe;
        r.rw = rw; r.mw = mw; r.pc = pc; r.st = st; r.fu = fu; r.rn = rn;
        r.evo = evo; r.ecx = ecx; r.ero = ero; r.emo = emo; r.epo = epo;
        r.efl = efl; r.esq = esq;
        return r;
    endfunction

    // Condition reference: even codes give the base test, odd codes its
    // inverse, top pair always executes.
    function automatic logic model_pass(logic [3:0] c, logic [3:0] f);
        logic n, z, cy, ov, base;
        n = f[3]; z = f[2]; cy = f[1]; ov = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = ov;
            3'd4:    base = cy & ~z;
            3'd5:    base = (n == ov);
            3'd6:    base = ~z & (n == ov);
            default: base = 1'b1;
        endcase
        return (c[3:1] == 3'd7) ? 1'b1 : (base ^ c[0]);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t vin, input string tag);
        vec_t e;
        valid_i = vin.v; cond_i = vin.cond; flags_i = vin.fl; flag_we_i = vin.fwe;
        reg_we_i = vin.rw; mem_we_i = vin.mw; pc_src_i = vin.pc;
        stall_i = vin.st; flush_i = vin.fu; rst_n = vin.rn;
        exp_q.push_back(vin);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".valid"},  {15'd0, valid_o},   {15'd0, e.evo});
        chk({tag, ".cex"},    {15'd0, cond_ex_o}, {15'd0, e.ecx});
        chk({tag, ".reg_we"}, {15'd0, reg_we_o},  {15'd0, e.ero});
        chk({tag, ".mem_we"}, {15'd0, mem_we_o},  {15'd0, e.emo});
        chk({tag, ".pc_src"}, {15'd0, pc_src_o},  {15'd0, e.epo});
        chk({tag, ".flags"},  {12'd0, flags_o},   {12'd0, e.efl});
`ifdef COND_UNIT_SQUASH_CNT_EN
        chk({tag, ".sq"}, squash_cnt_o, e.esq);
`endif
    endtask

    initial begin
        vec_t sv;
        logic c_pass;

        //            v cond  flags_i  fwe  rw mw pc st fu rn | vo cx ro mo po flags  sq
        tbl[0]  = mk(1, 4'hE, 4'b0100, 2'b11, 0,0,0,0,0,1, 1,1,0,0,0, 4'b0100, 0);
        tbl[1]  = mk(1, 4'h0, 4'b0000, 2'b00, 1,0,0,0,0,1, 1,1,1,0,0, 4'b0100, 0);
        tbl[2]  = mk(1, 4'h1, 4'b1111, 2'b11, 1,1,1,0,0,1, 1,0,0,0,0, 4'b0100, 1);
        tbl[3]  = mk(1, 4'hE, 4'b1000, 2'b11, 0,0,0,0,0,1, 1,1,0,0,0, 4'b1000, 1);
        tbl[4]  = mk(1, 4'hB, 4'b0000, 2'b00, 0,0,1,0,0,1, 1,1,0,0,1, 4'b1000, 1);
        tbl[5]  = mk(1, 4'hA, 4'b0000, 2'b00, 0,0,1,0,0,1, 1,0,0,0,0, 4'b1000, 2);
        tbl[6]  = mk(1, 4'hE, 4'b0000, 2'b11, 0,0,0,0,0,1, 1,1,0,0,0, 4'b0000, 2);
        tbl[7]  = mk(1, 4'hE, 4'b0011, 2'b10, 0,0,0,0,0,1, 1,1,0,0,0, 4'b0000, 2);
        tbl[8]  = mk(1, 4'hF, 4'b1111, 2'b01, 0,0,0,0,0,1, 1,1,0,0,0, 4'b0011, 2);
        tbl[9]  = mk(0, 4'hE, 4'b1111, 2'b11, 1,1,1,0,0,1, 0,0,0,0,0, 4'b0011, 2);
        tbl[10] = mk(1, 4'h2, 4'b0100, 2'b11, 1,1,1,0,0,1, 1,1,1,1,1, 4'b0100, 2);
        tbl[11] = mk(1, 4'hE, 4'b1111, 2'b11, 0,0,0,1,0,1, 1,1,1,1,1, 4'b0100, 2);
        tbl[12] = mk(1, 4'hE, 4'b1111, 2'b11, 0,0,0,1,0,1, 1,1,1,1,1, 4'b0100, 2);
        tbl[13] = mk(1, 4'hE, 4'b1111, 2'b11, 0,0,0,1,0,1, 1,1,1,1,1, 4'b0100, 2);
        tbl[14] = mk(1, 4'hE, 4'b1111, 2'b11, 0,0,0,1,1,1, 0,0,0,0,0, 4'b0100, 2);
        tbl[15] = mk(1, 4'hE, 4'b1111, 2'b11, 1,1,1,0,1,1, 0,0,0,0,0, 4'b0100, 2);
        tbl[16] = mk(1, 4'h5, 4'b0000, 2'b00, 0,1,0,0,0,1, 1,1,0,1,0, 4'b0100, 2);
        tbl[17] = mk(1, 4'hE, 4'b1111, 2'b11, 0,0,0,0,0,1, 1,1,0,0,0, 4'b1111, 2);
        tbl[18] = mk(1, 4'h1, 4'b0000, 2'b11, 1,1,1,1,0,1, 1,1,0,0,0, 4'b1111, 2);
        tbl[19] = mk(1, 4'hE, 4'b0101, 2'b11, 1,1,1,1,0,0, 0,0,0,0,0, 4'b0000, 0);
        tbl[20] = mk(1, 4'h8, 4'b1111, 2'b11, 1,0,0,0,0,1, 1,0,0,0,0, 4'b0000, 1);
        tbl[21] = mk(1, 4'h9, 4'b0000, 2'b00, 0,0,1,0,0,1, 1,1,0,0,1, 4'b0000, 1);

        // Reset with garbage on the inputs to show reset dominates.
        rst_n = 1'b0; valid_i = 1'b1; cond_i = 4'hE; flags_i = 4'hF; flag_we_i = 2'b11;
        reg_we_i = 1'b1; mem_we_i = 1'b1; pc_src_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid",  {15'd0, valid_o},   16'd0);
        chk("rst.cex",    {15'd0, cond_ex_o}, 16'd0);
        chk("rst.reg_we", {15'd0, reg_we_o},  16'd0);
        chk("rst.mem_we", {15'd0, mem_we_o},  16'd0);
        chk("rst.pc_src", {15'd0, pc_src_o},  16'd0);
        chk("rst.flags",  {12'd0, flags_o},   16'd0);
`ifdef COND_UNIT_SQUASH_CNT_EN
        chk("rst.sq", squash_cnt_o, 16'd0);
`endif

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Every condition against every flag state: load flags with AL, then
        // issue the condition while trying to overwrite flags with their
        // complement, which must only land when the condition passes.
        sq_model = int'(tbl[21].esq);
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                sv = mk(1, 4'hE, 4'(f), 2'b11, 0,0,0,0,0,1, 1,1,0,0,0, 4'(f), 16'(sq_model));
                apply(sv, $sformatf("ld%0d_%0d", f, c));
                c_pass = model_pass(4'(c), 4'(f));
                if (!c_pass) sq_model++;
                sv = mk(1, 4'(c), ~4'(f), 2'b11, 1,1,1,0,0,1,
                        1, c_pass, c_pass, c_pass, c_pass,
                        c_pass ? ~4'(f) : 4'(f), 16'(sq_model));
                apply(sv, $sformatf("cc f%0h c%0h", f, c));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
